// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus/field widths, instruction width helper, opcode encodings.
// Used by the instruction register, the decoder and the bench.
package cpu_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int OPCODE_W_DEF = 3;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  function automatic int instr_width(input int data_w, input int beats);
    return data_w * beats;
  endfunction

endpackage

// File: rtl/ir_beat_assembler_beat_counter.sv
// Wrapping 0..BEATS-1 counter, advances on inc, sync clear, async reset.
// last flags the final count; no backpressure, idx is registered.
module beat_counter #(
  parameter int BEATS = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  assign last = (idx == IDX_W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= last ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ir_beat_assembler.sv
// Builds a BEATS*DATA_W instruction from narrow bus loads, big-endian; result registered on the last beat
// (visible next cycle). Never stalls the bus: an unacked instruction is overwritten and flagged by sticky overrun.
module ir_beat_assembler
  import cpu_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int BEATS    = 2,
  parameter  int OPCODE_W = OPCODE_W_DEF,
  localparam int INSTR_W  = instr_width(DATA_W, BEATS),
  localparam int IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       data,
  input  logic                    load,
  input  logic                    clear,
  input  logic                    ack,
  output logic [INSTR_W-1:0]      instr,
  output logic [OPCODE_W-1:0]     opcode,
  output logic [INSTR_W-OPCODE_W-1:0] addr,
  output logic                    instr_valid,
  output logic [IDX_W-1:0]        beat_idx,
  output logic                    busy,
  output logic                    overrun
);

  logic [INSTR_W-1:0] staging;
  logic [INSTR_W-1:0] staged_next;
  logic               last_beat;
  logic               complete;

  beat_counter #(
    .BEATS (BEATS),
    .IDX_W (IDX_W)
  ) u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (load),
    .idx  (beat_idx),
    .last (last_beat)
  );

  // Staging with the current beat dropped into its slice; on the final beat this is the whole instruction.
  always_comb begin
    staged_next = staging;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_idx == IDX_W'(k)) begin
        staged_next[(BEATS-1-k)*DATA_W +: DATA_W] = data;
      end
    end
  end

  assign complete = load && !clear && last_beat;
  assign busy     = (beat_idx != '0);
  assign opcode   = instr[INSTR_W-1 -: OPCODE_W];
  assign addr     = instr[INSTR_W-OPCODE_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging <= '0;
    end else if (clear || complete) begin
      staging <= '0;
    end else if (load) begin
      staging <= staged_next;
    end
  end

  // instr deliberately survives clear; only a completion replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= '0;
    end else if (complete) begin
      instr <= staged_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (clear) begin
      instr_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (complete) begin
      instr_valid <= 1'b1;
      if (instr_valid && !ack) begin
        overrun <= 1'b1;
      end
    end else if (ack) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ir_beat_assembler.sv
// Directed bench for ir_beat_assembler: vector table on the 2-beat build, hand sequences for
// async reset, a 4-beat build and a 1-beat build.
module tb_ir_beat_assembler;
  import cpu_pkg::*;

  logic clk;
  logic rst;

  // 2-beat, 3-bit opcode
  logic [7:0]  a_data;
  logic        a_load, a_clear, a_ack;
  logic [15:0] a_instr;
  logic [2:0]  a_opcode;
  logic [12:0] a_addr;
  logic        a_valid, a_busy, a_ov;
  logic [0:0]  a_idx;

  // 4-beat, 5-bit opcode
  logic [7:0]  b_data;
  logic        b_load, b_clear, b_ack;
  logic [31:0] b_instr;
  logic [4:0]  b_opcode;
  logic [26:0] b_addr;
  logic        b_valid, b_busy, b_ov;
  logic [1:0]  b_idx;

  // 1-beat
  logic [7:0]  c_data;
  logic        c_load, c_clear, c_ack;
  logic [7:0]  c_instr;
  logic [2:0]  c_opcode;
  logic [4:0]  c_addr;
  logic        c_valid, c_busy, c_ov;
  logic [0:0]  c_idx;

  int n_chk  = 0;
  int n_fail = 0;

  ir_beat_assembler #(.DATA_W(8), .BEATS(2), .OPCODE_W(3)) dut_a (
    .clk(clk), .rst(rst), .data(a_data), .load(a_load), .clear(a_clear), .ack(a_ack),
    .instr(a_instr), .opcode(a_opcode), .addr(a_addr), .instr_valid(a_valid),
    .beat_idx(a_idx), .busy(a_busy), .overrun(a_ov)
  );

  ir_beat_assembler #(.DATA_W(8), .BEATS(4), .OPCODE_W(5)) dut_b (
    .clk(clk), .rst(rst), .data(b_data), .load(b_load), .clear(b_clear), .ack(b_ack),
    .instr(b_instr), .opcode(b_opcode), .addr(b_addr), .instr_valid(b_valid),
    .beat_idx(b_idx), .busy(b_busy), .overrun(b_ov)
  );

  ir_beat_assembler #(.DATA_W(8), .BEATS(1), .OPCODE_W(3)) dut_c (
    .clk(clk), .rst(rst), .data(c_data), .load(c_load), .clear(c_clear), .ack(c_ack),
    .instr(c_instr), .opcode(c_opcode), .addr(c_addr), .instr_valid(c_valid),
    .beat_idx(c_idx), .busy(c_busy), .overrun(c_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [7:0]  d;
    logic        clr;
    logic        ack;
    logic [15:0] e_instr;
    logic        e_vld;
    logic        e_busy;
    logic        e_ov;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic ld, input logic [7:0] d, input logic clr, input logic ack,
                              input logic [15:0] ei, input logic ev, input logic eb, input logic eo);
    vec_t v;
    v.ld = ld; v.d = d; v.clr = clr; v.ack = ack;
    v.e_instr = ei; v.e_vld = ev; v.e_busy = eb; v.e_ov = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all();
    a_load = 0; a_clear = 0; a_ack = 0; a_data = 8'h00;
    b_load = 0; b_clear = 0; b_ack = 0; b_data = 8'h00;
    c_load = 0; c_clear = 0; c_ack = 0; c_data = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    rst = 1'b1;

    // Outputs pinned at zero while reset is held, even with load active.
    @(negedge clk);
    a_load = 1; a_data = 8'hFF;
    step();
    chk("rst instr", 32'(a_instr), 32'h0);
    chk("rst valid", 32'(a_valid), 32'h0);
    chk("rst busy",  32'(a_busy),  32'h0);
    chk("rst idx",   32'(a_idx),   32'h0);
    chk("rst ovr",   32'(a_ov),    32'h0);
    idle_all();
    rst = 1'b0;

    //          ld  data   clr ack  instr     vld busy ov
    tv.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 0, 0, 0));
    tv.push_back(mk(1, 8'hA5, 0, 0, 16'h0000, 0, 1, 0));
    tv.push_back(mk(1, 8'h3C, 0, 0, 16'hA53C, 1, 0, 0));
    tv.push_back(mk(0, 8'h00, 0, 1, 16'hA53C, 0, 0, 0));
    tv.push_back(mk(1, 8'h12, 0, 0, 16'hA53C, 0, 1, 0));
    tv.push_back(mk(1, 8'h34, 0, 0, 16'h1234, 1, 0, 0));
    tv.push_back(mk(1, 8'hBE, 0, 0, 16'h1234, 1, 1, 0));
    tv.push_back(mk(1, 8'hEF, 0, 0, 16'hBEEF, 1, 0, 1));
    tv.push_back(mk(0, 8'h00, 1, 0, 16'hBEEF, 0, 0, 0));
    tv.push_back(mk(1, 8'h11, 0, 0, 16'hBEEF, 0, 1, 0));
    tv.push_back(mk(1, 8'h11, 0, 0, 16'h1111, 1, 0, 0));
    tv.push_back(mk(1, 8'h22, 0, 0, 16'h1111, 1, 1, 0));
    tv.push_back(mk(1, 8'h22, 0, 1, 16'h2222, 1, 0, 0));
    tv.push_back(mk(0, 8'h00, 0, 1, 16'h2222, 0, 0, 0));
    tv.push_back(mk(0, 8'h00, 0, 1, 16'h2222, 0, 0, 0));
    tv.push_back(mk(1, 8'hCC, 0, 0, 16'h2222, 0, 1, 0));
    for (int g = 0; g < 5; g++)
      tv.push_back(mk(0, 8'h00, 0, 0, 16'h2222, 0, 1, 0));
    tv.push_back(mk(1, 8'hDD, 0, 0, 16'hCCDD, 1, 0, 0));
    tv.push_back(mk(0, 8'h00, 0, 1, 16'hCCDD, 0, 0, 0));
    tv.push_back(mk(1, 8'h77, 0, 0, 16'hCCDD, 0, 1, 0));
    tv.push_back(mk(1, 8'h88, 1, 0, 16'hCCDD, 0, 0, 0));
    tv.push_back(mk(1, 8'h99, 0, 0, 16'hCCDD, 0, 1, 0));
    tv.push_back(mk(1, 8'h00, 0, 0, 16'h9900, 1, 0, 0));
    tv.push_back(mk(1, 8'hCC, 0, 0, 16'h9900, 1, 1, 0));

    foreach (tv[i]) begin
      a_load = tv[i].ld; a_data = tv[i].d; a_clear = tv[i].clr; a_ack = tv[i].ack;
      step();
      chk($sformatf("v%0d instr", i),  32'(a_instr),  32'(tv[i].e_instr));
      chk($sformatf("v%0d valid", i),  32'(a_valid),  32'(tv[i].e_vld));
      chk($sformatf("v%0d busy", i),   32'(a_busy),   32'(tv[i].e_busy));
      chk($sformatf("v%0d idx", i),    32'(a_idx),    32'(tv[i].e_busy));
      chk($sformatf("v%0d ovr", i),    32'(a_ov),     32'(tv[i].e_ov));
      chk($sformatf("v%0d opcode", i), 32'(a_opcode), 32'(tv[i].e_instr[15:13]));
      chk($sformatf("v%0d addr", i),   32'(a_addr),   32'(tv[i].e_instr[12:0]));
    end
    idle_all();

    // Hand-computed field split of the first instruction 16'hA53C.
    chk("a53c opcode", 32'(OP_LDA), 32'h5);

    // Async reset mid-cycle with a partial beat pending (busy=1, valid=1 from 9900).
    #2;
    rst = 1'b1;
    #1;
    chk("arst instr", 32'(a_instr), 32'h0);
    chk("arst valid", 32'(a_valid), 32'h0);
    chk("arst busy",  32'(a_busy),  32'h0);
    chk("arst idx",   32'(a_idx),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    a_load = 1; a_data = 8'h01;
    step();
    chk("post-rst beat0 busy", 32'(a_busy), 32'h1);
    a_data = 8'h02;
    step();
    chk("post-rst instr",  32'(a_instr),  32'h0102);
    chk("post-rst valid",  32'(a_valid),  32'h1);
    chk("post-rst opcode", 32'(a_opcode), 32'(OP_HLT));
    chk("post-rst addr",   32'(a_addr),   32'h0102);
    idle_all();

    // Four-beat build: beat index walks 1,2,3 and wraps to 0 on completion.
    b_load = 1;
    b_data = 8'h12; step(); chk("b4 idx1", 32'(b_idx), 32'h1); chk("b4 busy1", 32'(b_busy), 32'h1);
    b_data = 8'h34; step(); chk("b4 idx2", 32'(b_idx), 32'h2);
    b_data = 8'h56; step(); chk("b4 idx3", 32'(b_idx), 32'h3); chk("b4 vld pre", 32'(b_valid), 32'h0);
    chk("b4 instr pre", b_instr, 32'h0);
    b_data = 8'h78; step();
    chk("b4 idx wrap", 32'(b_idx),    32'h0);
    chk("b4 instr",    b_instr,       32'h12345678);
    chk("b4 opcode",   32'(b_opcode), 32'h02);
    chk("b4 addr",     32'(b_addr),   32'h2345678);
    chk("b4 valid",    32'(b_valid),  32'h1);
    chk("b4 busy",     32'(b_busy),   32'h0);
    idle_all();

    // Single-beat build: every load completes; a second unacked load overruns.
    c_load = 1; c_data = 8'h5A;
    step();
    chk("b1 instr",  32'(c_instr),  32'h5A);
    chk("b1 valid",  32'(c_valid),  32'h1);
    chk("b1 busy",   32'(c_busy),   32'h0);
    chk("b1 opcode", 32'(c_opcode), 32'h2);
    chk("b1 ovr0",   32'(c_ov),     32'h0);
    c_data = 8'hA5;
    step();
    chk("b1 instr2", 32'(c_instr),  32'hA5);
    chk("b1 ovr1",   32'(c_ov),     32'h1);
    c_load = 0; c_ack = 1;
    step();
    chk("b1 ack",    32'(c_valid),  32'h0);
    chk("b1 ovr sticky", 32'(c_ov), 32'h1);
    idle_all();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
